serial_subtractor: RTL and testbench

Bit-serial WIDTH-bit subtractor computing d = a - b - bin, one bit per clock, LSB first, with a borrow flip-flop. It is the subtract counterpart to the team's combinational ripple adder, for datapaths that trade latency for area. A start/busy/done handshake lets a controller FSM issue back-to-back operations. Results are held stable until the next completed operation.

---
 rtl/serial_subtractor.sv | 121 ++++++++++++
 tb/tb_serial_subtractor.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor d = a - b - bin, LSB first, one bit per clock.
// Define SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;

    logic             w_ai;
    logic             w_bi;
    logic             w_diff;
    logic             w_br_nx;
    logic             w_last;
    logic             w_load;

    assign w_ai    = r_a[r_cnt];
    assign w_bi    = r_b[r_cnt];
    assign w_diff  = w_ai ^ w_bi ^ r_br;
    assign w_br_nx = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
    assign w_last  = (r_cnt == CW'(WIDTH - 1));
    // start is accepted in IDLE and in DONE (back-to-back issue)
    assign w_load  = start && (r_state != S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  w_next = start ? S_RUN : S_IDLE;
            S_RUN:   w_next = w_last ? S_DONE : S_RUN;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_a   <= a;
            r_b   <= b;
            r_res <= '0;
            r_br  <= bin;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_res <= {w_diff, r_res[WIDTH-1:1]};
            r_br  <= w_br_nx;
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Results publish on the edge leaving DONE, together with the done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
            d    <= '0;
            bout <= 1'b0;
        end else begin
            done <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                d    <= r_res;
                bout <= r_br;
            end
        end
    end

`ifdef SUB_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (r_state == S_DONE) begin
            ovf <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                   (r_res[WIDTH-1] != r_a[WIDTH-1]);
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed vectors plus full sweep.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         bin   = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
`ifdef SUB_OVF_EN
    logic         ovf;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
`ifdef SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   input logic c);
        exp_t e;
        int   diff;
        diff   = int'(x) - int'(y) - int'(c);
        e.d    = W'(diff);
        e.bout = (diff < 0);
        e.ovf  = (x[W-1] != y[W-1]) && (e.d[W-1] != x[W-1]);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            if (q.size() == 0) begin
                check("unexpected_done", 32'(1), 32'(0));
            end else begin
                e = q.pop_front();
                check("d", 32'(d), 32'(e.d));
                check("bout", 32'(bout), 32'(e.bout));
`ifdef SUB_OVF_EN
                check("ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, input bit push);
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (busy) check("issue_timeout", 32'(1), 32'(0));
        a     = x;
        b     = y;
        bin   = c;
        start = 1'b1;
        if (push) q.push_back(model(x, y, c));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        int first;
        int second;
        int nd;
        int nb;
        int t;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_d", 32'(d), 32'(0));
        check("rst_bout", 32'(bout), 32'(0));
`ifdef SUB_OVF_EN
        check("rst_ovf", 32'(ovf), 32'(0));
`endif
        rst_n = 1'b1;

        // 9 - 3: latency and busy width
        issue(4'd9, 4'd3, 1'b0, 1'b1);
        first = -1;
        nd = 0;
        nb = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin
                nd++;
                if (first < 0) first = k;
            end
        end
        check("latency", 32'(first), 32'(6));
        check("done_count", 32'(nd), 32'(1));
        check("busy_cycles", 32'(nb), 32'(4));

        issue(4'd3, 4'd9, 1'b0, 1'b1);
        @(negedge clk);
        check("d_hold_run", 32'(d), 32'(6));
        issue(4'd0, 4'd0, 1'b1, 1'b1);
        repeat (8) @(negedge clk);

        // start held high: two ops, operand changes during RUN ignored
        @(negedge clk);
        a     = 4'd5;
        b     = 4'd5;
        bin   = 1'b0;
        start = 1'b1;
        q.push_back(model(4'd5, 4'd5, 1'b0));
        q.push_back(model(4'd5, 4'd5, 1'b0));
        first  = -1;
        second = -1;
        nd     = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            if (k == 1) begin
                a = 4'd3; b = 4'd12; bin = 1'b1;
            end
            if (k == 4) begin
                a = 4'd5; b = 4'd5; bin = 1'b0;
            end
            if (k == 6) begin
                a = 4'd9; b = 4'd2; bin = 1'b1;
            end
            if (k == 10) start = 1'b0;
        end
        check("b2b_first", 32'(first), 32'(6));
        check("b2b_second", 32'(second), 32'(11));
        check("b2b_count", 32'(nd), 32'(2));

        // asynchronous reset in the middle of RUN
        issue(4'd9, 4'd3, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        issue(4'd12, 4'd3, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'(0));
        check("arst_done", 32'(done), 32'(0));
        check("arst_d", 32'(d), 32'(0));
        check("arst_bout", 32'(bout), 32'(0));
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("no_done_after_rst", 32'(nd), 32'(0));
        issue(4'd14, 4'd5, 1'b1, 1'b1);

`ifdef SUB_OVF_EN
        issue(4'd8, 4'd1, 1'b0, 1'b1);
        issue(4'd7, 4'd1, 1'b0, 1'b1);
        issue(4'd15, 4'd1, 1'b0, 1'b1);
`endif

        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    issue(W'(ai), W'(bi), ci[0], 1'b1);
                end
            end
        end

        t = 0;
        while (q.size() > 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("queue_drain", 32'(q.size()), 32'(0));
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
